lsu_align: RTL

- Load/store alignment unit between the MEM-stage datapath and the data memory.
- Stores: generates the dmem word address, byte enables and lane-shifted write data.
- Loads: extracts, sign-extends or zero-extends the read word.
- Accesses that cross a word boundary are split into two dmem cycles, with a pipeline stall.

---
 rtl/lsu_align_if.sv | 34 +++
 rtl/lsu_align.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/lsu_align_if.sv
// lsu_align_if: bundle between the MEM-stage datapath, the load/store
// alignment unit and the data memory.
//   slave  : the alignment unit (takes the request and dmem_rd, drives the rest)
//   master : the datapath/memory side (drives the request and dmem_rd)
// Signals:
//   mem_read, mem_write, funct3, addr, wdata : MEM-stage request
//   rdata, stall, illegal                    : results back to the pipeline
//   dmem_we, dmem_be, dmem_a, dmem_wd        : data memory write/address side
//   dmem_rd                                  : data memory combinational read data
interface lsu_align_if;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        illegal;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_a;
  logic [31:0] dmem_wd;
  logic [31:0] dmem_rd;

  modport slave (
    input  mem_read, mem_write, funct3, addr, wdata, dmem_rd,
    output rdata, stall, illegal, dmem_we, dmem_be, dmem_a, dmem_wd
  );

  modport master (
    output mem_read, mem_write, funct3, addr, wdata, dmem_rd,
    input  rdata, stall, illegal, dmem_we, dmem_be, dmem_a, dmem_wd
  );
endinterface

// File: rtl/lsu_align.sv
// lsu_align: load/store alignment unit between the MEM stage and data memory.
// Stores get a word address, byte enables and lane-shifted write data; loads
// get the addressed bytes extracted and sign/zero-extended. Accesses crossing
// a word boundary take two dmem cycles (stall asserted in the first) when
// SUPPORT_MISALIGNED=1, otherwise they are rejected as illegal.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : lsu_align_if.slave (request, results and dmem signals)
module lsu_align #(
  parameter bit SUPPORT_MISALIGNED = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  lsu_align_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } state_t;

  state_t      state_r;
  logic [31:0] hold_r;

  logic [1:0]  o_s;
  logic [2:0]  n_s;
  logic [3:0]  mask_s;
  logic        req_s;
  logic        size_bad_s;
  logic        cross_s;
  logic        illegal_s;
  logic [31:0] a_s;
  logic [7:0]  be_wide_s;
  logic [63:0] wd_wide_s;
  logic [63:0] rd_wide_s;
  logic [31:0] rd_shift_s;
  logic [31:0] load_s;

  // Decode size, offset, word crossing and legality of the current request.
  always_comb begin
    o_s = bus.addr[1:0];
    case (bus.funct3[1:0])
      2'b00:   begin n_s = 3'd1; mask_s = 4'b0001; end
      2'b01:   begin n_s = 3'd2; mask_s = 4'b0011; end
      2'b10:   begin n_s = 3'd4; mask_s = 4'b1111; end
      default: begin n_s = 3'd0; mask_s = 4'b0000; end
    endcase
    req_s      = bus.mem_read | bus.mem_write;
    // 011, 11x, and unsigned (1xx) encodings on a store have no meaning.
    size_bad_s = (bus.funct3[1:0] == 2'b11) | (bus.funct3[2] & bus.funct3[1]) |
                 (bus.funct3[2] & bus.mem_write);
    cross_s    = (({1'b0, n_s} + {2'b00, o_s}) > 4'd4);
    illegal_s  = req_s & ((bus.mem_read & bus.mem_write) | size_bad_s |
                          (cross_s & ~SUPPORT_MISALIGNED));
    a_s        = {bus.addr[31:2], 2'b00};
  end

  // Lane shifting: the low halves serve the first (or only) word, the high
  // halves the second word of a crossing access.
  always_comb begin
    be_wide_s  = {4'b0000, mask_s} << o_s;
    wd_wide_s  = {32'h0000_0000, bus.wdata} << {o_s, 3'b000};
    rd_wide_s  = (state_r == SECOND) ? {bus.dmem_rd, hold_r} : {32'h0000_0000, bus.dmem_rd};
    rd_shift_s = 32'(rd_wide_s >> {o_s, 3'b000});
    case (bus.funct3[1:0])
      2'b00: begin
        if (bus.funct3[2]) begin
          load_s = {24'h00_0000, rd_shift_s[7:0]};
        end else begin
          load_s = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
        end
      end
      2'b01: begin
        if (bus.funct3[2]) begin
          load_s = {16'h0000, rd_shift_s[15:0]};
        end else begin
          load_s = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
        end
      end
      default: load_s = rd_shift_s;
    endcase
  end

  // Output selection; reset and illegal requests force every strobe low.
  always_comb begin
    bus.rdata   = 32'h0000_0000;
    bus.stall   = 1'b0;
    bus.illegal = 1'b0;
    bus.dmem_we = 1'b0;
    bus.dmem_be = 4'b0000;
    bus.dmem_a  = (state_r == SECOND) ? (a_s + 32'd4) : a_s;
    bus.dmem_wd = wd_wide_s[31:0];
    if (reset) begin
      bus.illegal = 1'b0;
    end else if (illegal_s) begin
      bus.illegal = 1'b1;
    end else if (!req_s) begin
      bus.rdata = 32'h0000_0000;
    end else if (state_r == SECOND) begin
      bus.dmem_we = bus.mem_write;
      bus.dmem_be = bus.mem_write ? be_wide_s[7:4] : 4'b0000;
      bus.dmem_wd = wd_wide_s[63:32];
      bus.rdata   = bus.mem_read ? load_s : 32'h0000_0000;
    end else if (cross_s) begin
      // First half of a split access: the load result is not ready yet.
      bus.stall   = 1'b1;
      bus.dmem_we = bus.mem_write;
      bus.dmem_be = bus.mem_write ? be_wide_s[3:0] : 4'b0000;
    end else begin
      bus.dmem_we = bus.mem_write;
      bus.dmem_be = bus.mem_write ? be_wide_s[3:0] : 4'b0000;
      bus.rdata   = bus.mem_read ? load_s : 32'h0000_0000;
    end
  end

  // Split-access FSM; hold keeps the first word of a crossing load.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      hold_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s && !illegal_s && cross_s) begin
            hold_r  <= bus.dmem_rd;
            state_r <= SECOND;
          end else begin
            state_r <= IDLE;
          end
        end
        SECOND: begin
          // Completion and flush both return to IDLE; a rejected request waits.
          if (illegal_s) begin
            state_r <= SECOND;
          end else begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
